// File: rtl/fpu_ctrl_pkg.sv
// Shared types, opcode/funct5 constants and RV32F register-usage decode
// for the FPU issue controller.
package fpu_ctrl_pkg;

  localparam int unsigned MAX_ID_WIDTH = 16;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  localparam logic [4:0] F5_ADD     = 5'b00000;
  localparam logic [4:0] F5_SUB     = 5'b00001;
  localparam logic [4:0] F5_MUL     = 5'b00010;
  localparam logic [4:0] F5_DIV     = 5'b00011;
  localparam logic [4:0] F5_SGNJ    = 5'b00100;
  localparam logic [4:0] F5_MINMAX  = 5'b00101;
  localparam logic [4:0] F5_CMP     = 5'b10100;
  localparam logic [4:0] F5_CVT_W_S = 5'b11000;
  localparam logic [4:0] F5_MV_X_W  = 5'b11100;
  localparam logic [4:0] F5_CVT_S_W = 5'b11010;
  localparam logic [4:0] F5_MV_W_X  = 5'b11110;

  // One tracked in-flight op; id is stored at its widest legal size.
  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0] id;
    logic [4:0]              rd;
    logic                    wr_fp;
  } inflight_entry_t;

  typedef struct packed {
    logic wr_fp;
    logic rd_rs1;
    logic rd_rs2;
    logic rd_rs3;
  } fp_decode_t;

  function automatic logic is_fp_opcode(input logic [6:0] opc);
    return opc inside {OPC_LOAD_FP, OPC_STORE_FP, OPC_OP_FP,
                       OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD};
  endfunction

  // Which FP registers an instruction reads and whether it writes FP rd.
  function automatic fp_decode_t fp_decode(input logic [6:0] opc, input logic [4:0] f5);
    fp_decode_t d;
    d = '0;
    case (opc)
      OPC_LOAD_FP:  d.wr_fp = 1'b1;
      OPC_STORE_FP: d.rd_rs2 = 1'b1;
      OPC_OP_FP: begin
        d.wr_fp  = !(f5 inside {F5_CMP, F5_CVT_W_S, F5_MV_X_W});
        d.rd_rs1 = !(f5 inside {F5_CVT_S_W, F5_MV_W_X});
        d.rd_rs2 = f5 inside {F5_ADD, F5_SUB, F5_MUL, F5_DIV, F5_SGNJ, F5_MINMAX, F5_CMP};
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: d = '{1'b1, 1'b1, 1'b1, 1'b1};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fpu_inflight_fifo.sv
// In-order tracker of launched FPU ops; exposes the head entry and the id
// of the entry behind it so a result can be matched while one is buffered.
module fpu_inflight_fifo
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           ck,
  input  logic                           rst,
  input  logic                           push,
  input  inflight_entry_t                push_data,
  input  logic                           pop,
  output inflight_entry_t                head,
  output logic [MAX_ID_WIDTH-1:0]        head_next_id,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  inflight_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign do_push      = push && !full;
  assign do_pop       = pop && !empty;
  assign head         = mem[rd_ptr];
  assign head_next_id = mem[next_ptr(rd_ptr)].id;

  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: hazard scoreboard, in-flight limiting, launch
// strobe and a one-entry in-order result buffer with datapath backpressure.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned X_ID_WIDTH      = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  output logic                  issue_accept,
  output logic                  fpu_enable,
  output logic [31:0]           fpu_instr,
  output logic [X_ID_WIDTH-1:0] fpu_id,
  output logic                  fpu_hold,
  input  logic                  dp_res_valid,
  input  logic [X_ID_WIDTH-1:0] dp_res_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [X_ID_WIDTH-1:0] res_id,
  output logic                  err
);

  localparam int unsigned REG_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(PIPELINE_STAGES + 1);

  logic [NUM_REGS-1:0]     sb_q;
  logic [NUM_REGS-1:0]     sb_d;
  fp_decode_t              dec;
  logic [4:0]              rd, rs1, rs2, rs3;
  logic                    hazard;
  logic                    launch;
  logic                    res_fire;
  logic                    entry_avail;
  logic [MAX_ID_WIDTH-1:0] expect_id;
  logic                    dp_take;
  logic                    dp_err;
  inflight_entry_t         push_entry;
  inflight_entry_t         head;
  logic [MAX_ID_WIDTH-1:0] head_next_id;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign rd  = issue_instr[11:7];
  assign rs1 = issue_instr[19:15];
  assign rs2 = issue_instr[24:20];
  assign rs3 = issue_instr[31:27];
  assign dec = fp_decode(issue_instr[6:0], issue_instr[31:27]);

  assign hazard = (dec.rd_rs1 && sb_q[REG_W'(rs1)]) ||
                  (dec.rd_rs2 && sb_q[REG_W'(rs2)]) ||
                  (dec.rd_rs3 && sb_q[REG_W'(rs3)]) ||
                  (dec.wr_fp  && sb_q[REG_W'(rd)]);

  assign fpu_hold     = res_valid && !res_ready;
  assign issue_ready  = rst && !hazard && !fifo_full && !fpu_hold;
  assign issue_accept = is_fp_opcode(issue_instr[6:0]);
  assign launch       = issue_valid && issue_ready && issue_accept;
  assign res_fire     = res_valid && res_ready;

  // While a result sits in the buffer the head is already answered, so the
  // next datapath result belongs to the entry behind it.
  assign expect_id   = res_valid ? head_next_id : head.id;
  assign entry_avail = res_valid ? (fifo_count > CNT_W'(1)) : !fifo_empty;
  assign dp_take     = dp_res_valid && !fpu_hold && entry_avail &&
                       (expect_id == MAX_ID_WIDTH'(dp_res_id));
  assign dp_err      = dp_res_valid && !dp_take;

  assign push_entry = '{id: MAX_ID_WIDTH'(issue_id), rd: rd, wr_fp: dec.wr_fp};

  // Clear on retire first so a same-cycle set of the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (res_fire && head.wr_fp) sb_d[REG_W'(head.rd)] = 1'b0;
    if (launch && dec.wr_fp)    sb_d[REG_W'(rd)]      = 1'b1;
  end

  fpu_inflight_fifo #(
    .DEPTH (PIPELINE_STAGES)
  ) u_fifo (
    .ck           (ck),
    .rst          (rst),
    .push         (launch),
    .push_data    (push_entry),
    .pop          (res_fire),
    .head         (head),
    .head_next_id (head_next_id),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_ff @(posedge ck) begin
    if (!rst) begin
      sb_q       <= '0;
      fpu_enable <= 1'b0;
      fpu_instr  <= '0;
      fpu_id     <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      err        <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      fpu_enable <= launch;
      if (launch) begin
        fpu_instr <= issue_instr;
        fpu_id    <= issue_id;
      end
      if (dp_take) begin
        res_valid <= 1'b1;
        res_id    <= dp_res_id;
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
      if (dp_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: expected result ids are queued at
// issue and compared in order at each result handshake.
module tb_fpu_issue_ctrl;

  logic        ck = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic        issue_accept;
  logic        fpu_enable;
  logic [31:0] fpu_instr;
  logic [3:0]  fpu_id;
  logic        fpu_hold;
  logic        dp_res_valid;
  logic [3:0]  dp_res_id;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_id;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q [$];

  always #5 ck = ~ck;

  fpu_issue_ctrl #(
    .NUM_REGS        (32),
    .PIPELINE_STAGES (4),
    .X_ID_WIDTH      (4)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_id     (issue_id),
    .issue_accept (issue_accept),
    .fpu_enable   (fpu_enable),
    .fpu_instr    (fpu_instr),
    .fpu_id       (fpu_id),
    .fpu_hold     (fpu_hold),
    .dp_res_valid (dp_res_valid),
    .dp_res_id    (dp_res_id),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .err          (err)
  );

  function automatic logic [31:0] fadd(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  // Offer one instruction, wait (bounded) for ready, complete the handshake.
  task automatic issue(input logic [31:0] instr, input logic [3:0] id, output logic ok);
    int w;
    w = 0;
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_id    = id;
    #1;
    while (!issue_ready && w < 20) begin
      cyc();
      w++;
    end
    ok = issue_ready;
    if (ok) begin
      if (issue_accept) exp_q.push_back(id);
      cyc();
    end
    issue_valid = 1'b0;
  endtask

  task automatic dp(input logic [3:0] id);
    dp_res_valid = 1'b1;
    dp_res_id    = id;
    cyc();
    dp_res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    issue_valid = 1'b0;
    dp_res_valid = 1'b0;
    res_ready = 1'b0;
    cyc();
    rst = 1'b1;
    exp_q.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    issue_valid = 1'b1;
    issue_instr = 32'h002081D3;
    issue_id = 4'd1;
    dp_res_valid = 1'b0;
    dp_res_id = 4'd0;
    res_ready = 1'b0;
    repeat (3) begin
      cyc();
      n_checks++;
      if ({issue_ready, fpu_enable, res_valid, fpu_hold, err} !== 5'b0 ||
          fpu_instr !== 32'h0 || fpu_id !== 4'h0 || res_id !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: rdy=%b en=%b rv=%b hold=%b err=%b instr=%h id=%h rid=%h, all required 0",
                 issue_ready, fpu_enable, res_valid, fpu_hold, err, fpu_instr, fpu_id, res_id);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: issue_ready=%b required 1", issue_ready);
    end
    issue_valid = 1'b0;
    #1;
  endtask

  task automatic test_raw_hazard();
    logic ok;
    logic stalled;
    res_ready = 1'b0;
    issue(32'h002081D3, 4'd1, ok);
    n_checks++;
    if (!ok || fpu_enable !== 1'b1 || fpu_id !== 4'd1) begin
      n_fail++;
      $display("FAIL fadd_launch: ok=%b fpu_enable=%b fpu_id=%0d required 1/1/1", ok, fpu_enable, fpu_id);
    end
    n_checks++;
    if (fpu_instr !== 32'h002081D3) begin
      n_fail++;
      $display("FAIL fadd_instr: fpu_instr=%h required 002081d3", fpu_instr);
    end
    issue_valid = 1'b1;
    issue_instr = 32'h10118253;
    issue_id = 4'd2;
    #1;
    stalled = 1'b1;
    repeat (3) begin
      if (issue_ready !== 1'b0) stalled = 1'b0;
      cyc();
    end
    n_checks++;
    if (!stalled || fpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall: stalled=%b fpu_enable=%b required 1/0", stalled, fpu_enable);
    end
    dp_res_valid = 1'b1;
    dp_res_id = 4'd1;
    cyc();
    dp_res_valid = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== exp_q[0] || issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fadd_result: res_valid=%b res_id=%0d issue_ready=%b required 1/%0d/0",
               res_valid, res_id, issue_ready, exp_q[0]);
    end
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_no_bypass: issue_ready=%b required 0 during handshake", issue_ready);
    end
    void'(exp_q.pop_front());
    cyc();
    n_checks++;
    if (res_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release: res_valid=%b issue_ready=%b required 0/1", res_valid, issue_ready);
    end
    exp_q.push_back(4'd2);
    cyc();
    issue_valid = 1'b0;
    n_checks++;
    if (fpu_enable !== 1'b1 || fpu_id !== 4'd2 || fpu_instr !== 32'h10118253) begin
      n_fail++;
      $display("FAIL fmul_launch: fpu_enable=%b fpu_id=%0d instr=%h required 1/2/10118253",
               fpu_enable, fpu_id, fpu_instr);
    end
    dp(4'd2);
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL fmul_result: res_valid=%b res_id=%0d required 1/2", res_valid, res_id);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic all_ok;
    logic [3:0] exp_id;
    int hs;
    int last_hs;
    logic gap;
    int acc_c;
    res_ready = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(fadd(5'(5 + i), 5'd0, 5'd0), 4'(i), ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL b2b_fill: accepted=%b required 1", all_ok);
    end
    issue_valid = 1'b1;
    issue_instr = fadd(5'd9, 5'd0, 5'd0);
    issue_id = 4'd4;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_stall: issue_ready=%b required 0 at count 4", issue_ready);
    end
    cyc();
    hs = 0;
    last_hs = -1;
    gap = 1'b0;
    acc_c = -1;
    for (int c = 0; c < 7; c++) begin
      dp_res_valid = (c < 5);
      dp_res_id = 4'(c);
      #1;
      if (res_valid && res_ready) begin
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (res_id !== exp_id) begin
          n_fail++;
          $display("FAIL b2b_res_id: res_id=%0d required %0d", res_id, exp_id);
        end
        if (hs > 0 && last_hs != c - 1) gap = 1'b1;
        last_hs = c;
        hs++;
      end
      if (issue_valid && issue_ready) begin
        exp_q.push_back(4'd4);
        acc_c = c;
      end
      cyc();
      if (c == acc_c) begin
        issue_valid = 1'b0;
        n_checks++;
        if (fpu_enable !== 1'b1 || fpu_id !== 4'd4) begin
          n_fail++;
          $display("FAIL b2b_fifth_launch: fpu_enable=%b fpu_id=%0d required 1/4", fpu_enable, fpu_id);
        end
      end
    end
    dp_res_valid = 1'b0;
    issue_valid = 1'b0;
    n_checks++;
    if (hs != 5 || gap || acc_c != 2 || err !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flow: handshakes=%0d gap=%b accept_cycle=%0d err=%b res_valid=%b required 5/0/2/0/0",
               hs, gap, acc_c, err, res_valid);
    end
  endtask

  task automatic test_hold_err();
    logic ok;
    res_ready = 1'b0;
    issue(fadd(5'd10, 5'd0, 5'd0), 4'd5, ok);
    issue(fadd(5'd11, 5'd0, 5'd0), 4'd6, ok);
    dp(4'd5);
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 4'd5 || fpu_hold !== 1'b1 || issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_assert: rv=%b rid=%0d hold=%b rdy=%b required 1/5/1/0",
               res_valid, res_id, fpu_hold, issue_ready);
    end
    dp(4'd6);
    n_checks++;
    if (err !== 1'b1 || res_id !== 4'd5) begin
      n_fail++;
      $display("FAIL hold_drop_err: err=%b res_id=%0d required 1/5", err, res_id);
    end
    res_ready = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
    do_reset();
  endtask

  task automatic test_id_mismatch();
    logic ok;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset_clear: err=%b required 0", err);
    end
    res_ready = 1'b1;
    issue(fadd(5'd12, 5'd0, 5'd0), 4'd0, ok);
    issue(fadd(5'd13, 5'd0, 5'd0), 4'd1, ok);
    dp(4'd3);
    n_checks++;
    if (err !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL id_mismatch: err=%b res_valid=%b required 1/0", err, res_valid);
    end
    do_reset();
    dp(4'd0);
    n_checks++;
    if (err !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_result: err=%b res_valid=%b required 1/0", err, res_valid);
    end
    do_reset();
  endtask

  task automatic test_non_fp();
    logic ok;
    logic all_ok;
    logic [3:0] exp_id;
    int hs;
    issue_valid = 1'b1;
    issue_instr = 32'h00000033;
    issue_id = 4'd7;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1 || issue_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL int_offer: issue_ready=%b issue_accept=%b required 1/0", issue_ready, issue_accept);
    end
    cyc();
    issue_valid = 1'b0;
    n_checks++;
    if (fpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL int_no_launch: fpu_enable=%b required 0", fpu_enable);
    end
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(fadd(5'(14 + i), 5'd0, 5'd0), 4'(8 + i), ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL int_count_unchanged: four FP issues accepted=%b required 1", all_ok);
    end
    res_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      dp_res_valid = (c < 4);
      dp_res_id = 4'(8 + c);
      #1;
      if (res_valid && res_ready) begin
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (res_id !== exp_id) begin
          n_fail++;
          $display("FAIL int_drain_id: res_id=%0d required %0d", res_id, exp_id);
        end
        hs++;
      end
      cyc();
    end
    dp_res_valid = 1'b0;
    n_checks++;
    if (hs != 4 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL int_drain: handshakes=%0d err=%b required 4/0", hs, err);
    end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_back_to_back();
    test_hold_err();
    test_id_mismatch();
    test_non_fp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
